// File: rtl/fmdll_cfg_seq.sv
// Sequences an (M, N) ratio into the DLL under reset, then qualifies its lock.
// Latency: M/N and HOLD one edge after accept; lock RST_CYC+SETTLE_CYC+4 cycles after that.
// Backpressure: cfg_ready only in IDLE/LOCKED/ERROR; requests offered while busy are dropped.
module fmdll_cfg_seq #(
  parameter int RST_CYC     = 8,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_M,
  input  logic [3:0] cfg_N,
  input  logic       dll_lock_in,
  output logic [1:0] M,
  output logic [3:0] N,
  output logic       dll_rst_n,
  output logic       busy,
  output logic       locked,
  output logic       timeout_err,
  output logic       cfg_err,
  output logic       lock_lost
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  // Terminal counts: each phase ends on the edge where the counter reaches N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       filt_q, filt_d;
  logic             sync1_q, sync2_q;
  logic             lock_s;
  logic [1:0]       m_q, m_d;
  logic [3:0]       n_q, n_d;
  logic             cfg_err_q, cfg_err_d;
  logic             lock_lost_q, lock_lost_d;
  logic             dll_rst_n_q, dll_rst_n_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             timeout_err_q, timeout_err_d;
  logic             accept, cfg_bad;

  assign lock_s    = sync2_q;
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_ERROR);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_M == 2'd0) || (cfg_N == 4'd0);

  // Two-flop synchronizer for the asynchronous DLL lock indication.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= dll_lock_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state: phase sequencing, lock filter, then request handling on top.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    filt_d      = filt_q;
    m_d         = m_q;
    n_d         = n_q;
    cfg_err_d   = 1'b0;
    lock_lost_d = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          filt_d  = 2'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        // Qualification is tested before the timeout so lock wins a tie.
        if (lock_s && (filt_q == 2'd3)) begin
          state_d = S_LOCKED;
          filt_d  = 2'd0;
        end else begin
          filt_d = lock_s ? (filt_q + 2'd1) : 2'd0;
          if (cnt_q == TO_LAST) begin
            state_d = S_ERROR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_LOCKED: begin
        if (!lock_s && (filt_q == 2'd3)) begin
          state_d     = S_WAIT;
          lock_lost_d = 1'b1;
          cnt_d       = '0;
          filt_d      = 2'd0;
        end else begin
          filt_d = !lock_s ? (filt_q + 2'd1) : 2'd0;
        end
      end
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase

    // A bad ratio only raises cfg_err; a good one restarts from HOLD silently.
    if (accept) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        state_d     = S_HOLD;
        cnt_d       = '0;
        filt_d      = 2'd0;
        m_d         = cfg_M;
        n_d         = cfg_N;
        lock_lost_d = 1'b0;
      end
    end
  end

  // Status flags are registered from the next state so they never glitch.
  always_comb begin
    dll_rst_n_d   = (state_d == S_SETTLE) || (state_d == S_WAIT) || (state_d == S_LOCKED);
    busy_d        = (state_d == S_HOLD) || (state_d == S_SETTLE) || (state_d == S_WAIT);
    locked_d      = (state_d == S_LOCKED);
    timeout_err_d = (state_d == S_ERROR);
  end

  // State, counters, ratio and status registers.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      filt_q        <= 2'd0;
      m_q           <= 2'd0;
      n_q           <= 4'd0;
      cfg_err_q     <= 1'b0;
      lock_lost_q   <= 1'b0;
      dll_rst_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      locked_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      filt_q        <= filt_d;
      m_q           <= m_d;
      n_q           <= n_d;
      cfg_err_q     <= cfg_err_d;
      lock_lost_q   <= lock_lost_d;
      dll_rst_n_q   <= dll_rst_n_d;
      busy_q        <= busy_d;
      locked_q      <= locked_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign M           = m_q;
  assign N           = n_q;
  assign dll_rst_n   = dll_rst_n_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_err_q;
  assign cfg_err     = cfg_err_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_fmdll_cfg_seq.sv
// Scoreboard bench for fmdll_cfg_seq: stimulus queues full output snapshots
// keyed by edge count; a negedge monitor pops and compares them.
// Cycle k+n (counting from accept edge k) is observed after edge k+n-1.
module tb_fmdll_cfg_seq;

  logic       clk_ext = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_M;
  logic [3:0] cfg_N;
  logic       dll_lock_in;
  logic [1:0] M;
  logic [3:0] N;
  logic       dll_rst_n, busy, locked, timeout_err, cfg_err, lock_lost;

  fmdll_cfg_seq dut (
    .clk_ext     (clk_ext),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_M       (cfg_M),
    .cfg_N       (cfg_N),
    .dll_lock_in (dll_lock_in),
    .M           (M),
    .N           (N),
    .dll_rst_n   (dll_rst_n),
    .busy        (busy),
    .locked      (locked),
    .timeout_err (timeout_err),
    .cfg_err     (cfg_err),
    .lock_lost   (lock_lost)
  );

  always #5 clk_ext = ~clk_ext;

  int cyc = 0;
  always @(posedge clk_ext) cyc <= cyc + 1;

  // Snapshot: {cfg_ready, M, N, dll_rst_n, busy, locked, timeout_err, cfg_err, lock_lost}
  logic [12:0] obs;
  assign obs = {cfg_ready, M, N, dll_rst_n, busy, locked, timeout_err, cfg_err, lock_lost};

  int          q_cyc[$];
  logic [12:0] q_val[$];
  string       q_tag[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  int          m_cyc;
  logic [12:0] m_val;
  string       m_tag;

  task automatic expect_at(input int c, input string tag, input logic rdy,
                           input logic [1:0] m, input logic [3:0] n, input logic rstn,
                           input logic bsy, input logic lk, input logic to,
                           input logic ce, input logic ll);
    q_cyc.push_back(c);
    q_val.push_back({rdy, m, n, rstn, bsy, lk, to, ce, ll});
    q_tag.push_back(tag);
  endtask

  // Monitor: compare every expectation due at or before the current edge count.
  always @(negedge clk_ext) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      m_cyc = q_cyc.pop_front();
      m_val = q_val.pop_front();
      m_tag = q_tag.pop_front();
      n_vec++;
      if (m_cyc != cyc || obs !== m_val) begin
        n_fail++;
        $display("FAIL %s at edge %0d (due %0d): got rdy/M/N/rstn/busy/lk/to/ce/ll=%b required %b",
                 m_tag, cyc, m_cyc, obs, m_val);
      end
    end
  end

  task automatic request(input logic [1:0] m, input logic [3:0] n, output int k);
    cfg_valid = 1'b1;
    cfg_M     = m;
    cfg_N     = n;
    k         = cyc + 1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_ext);
  endtask

  initial begin
    int k, k2, c;
    logic lk;
    rst = 1'b1; cfg_valid = 1'b0; cfg_M = 2'd0; cfg_N = 4'd0; dll_lock_in = 1'b1;

    // Reset state
    @(negedge clk_ext);
    expect_at(cyc + 1, "reset_state", 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_ext);
    rst = 1'b0;
    expect_at(cyc + 1, "idle_after_reset", 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);

    // M=2 N=5 with lock held high
    request(2'd2, 4'd5, k);
    expect_at(k,      "A_hold_start",  1'b0, 2'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 7,  "A_hold_last",   1'b0, 2'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 8,  "A_rst_release", 1'b0, 2'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 75, "A_wait_lock",   1'b0, 2'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 76, "A_locked",      1'b1, 2'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);
    cfg_valid = 1'b0;
    wait_until(k + 78);

    n_vec++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL A_direct_locked: locked=%b required 1", locked);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL A_direct_busy: busy=%b required 0", busy);
    end
    n_vec++;
    if (M !== 2'd2) begin
      n_fail++;
      $display("FAIL A_direct_M: M=%0d required 2", M);
    end
    n_vec++;
    if (N !== 4'd5) begin
      n_fail++;
      $display("FAIL A_direct_N: N=%0d required 5", N);
    end

    // 3-cycle lock glitch: no effect
    c = cyc;
    dll_lock_in = 1'b0;
    for (int i = 1; i <= 10; i++)
      expect_at(c + i, "G_glitch", 1'b1, 2'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_ext);
    dll_lock_in = 1'b1;
    wait_until(c + 12);

    // 10-cycle lock drop: loss after 2+4 cycles, relock 4 cycles after sync
    c = cyc;
    dll_lock_in = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      lk = (i < 6) || (i >= 16);
      expect_at(c + i, "L_drop", lk, 2'd2, 4'd5, 1'b1, !lk, lk, 1'b0, 1'b0, (i == 6));
    end
    repeat (10) @(negedge clk_ext);
    dll_lock_in = 1'b1;
    wait_until(c + 19);

    n_vec++;
    if (locked !== 1'b1 || lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL L_direct_relock: locked=%b lock_lost=%b required 1/0", locked, lock_lost);
    end

    // Rejected requests in LOCKED
    request(2'd3, 4'd0, k);
    expect_at(k,     "R_err_N0",   1'b1, 2'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_at(k + 1, "R_clear_N0", 1'b1, 2'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);
    cfg_valid = 1'b0;
    wait_until(k + 2);
    request(2'd0, 4'd4, k);
    expect_at(k,     "R_err_M0",   1'b1, 2'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_at(k + 1, "R_clear_M0", 1'b1, 2'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);
    cfg_valid = 1'b0;
    wait_until(k + 2);

    // M=1 N=3 with no lock: timeout
    request(2'd1, 4'd3, k);
    dll_lock_in = 1'b0;
    expect_at(k,        "B_hold",        1'b0, 2'd1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 8,    "B_rst_release", 1'b0, 2'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 1095, "B_wait_last",   1'b0, 2'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 1096, "B_timeout",     1'b1, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at(k + 1100, "B_error_hold",  1'b1, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_ext);
    cfg_valid = 1'b0;
    wait_until(k + 1101);

    n_vec++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL B_direct_timeout: timeout_err=%b required 1", timeout_err);
    end
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL B_direct_ready: cfg_ready=%b required 1", cfg_ready);
    end
    n_vec++;
    if (dll_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL B_direct_rstn: dll_rst_n=%b required 0", dll_rst_n);
    end

    // New request from ERROR clears timeout_err
    request(2'd2, 4'd7, k);
    dll_lock_in = 1'b1;
    expect_at(k,      "E_new_req", 1'b0, 2'd2, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 10, "S_settle",  1'b0, 2'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);
    cfg_valid = 1'b0;
    wait_until(k + 10);

    // Request while busy is ignored
    request(2'd3, 4'd9, k2);
    expect_at(k2, "S_busy_ignored", 1'b0, 2'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);

    // Reset mid-SETTLE with a request pending
    c = cyc;
    rst = 1'b1;
    expect_at(c + 1, "X_reset",      1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(c + 2, "X_idle",       1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(c + 4, "X_idle_later", 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_ext);
    rst = 1'b0;
    cfg_valid = 1'b0;
    wait_until(c + 6);

    n_vec++;
    if (M !== 2'd0 || N !== 4'd0) begin
      n_fail++;
      $display("FAIL X_direct_MN: M=%0d N=%0d required 0/0", M, N);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL X_direct_busy: busy=%b required 0", busy);
    end

    // Drain, then count anything never observed as a failure
    for (int i = 0; i < 60 && q_cyc.size() > 0; i++) @(negedge clk_ext);
    while (q_cyc.size() > 0) begin
      m_cyc = q_cyc.pop_front();
      m_val = q_val.pop_front();
      m_tag = q_tag.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL %s never compared (due edge %0d, now %0d): got nothing required %b",
               m_tag, m_cyc, cyc, m_val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
